pipe_ctrl_unit: RTL and testbench

//  Pipelined successor to the combinational opcode decoder. Decodes the ID-stage opcode
//  and carries the control bits through the ID/EX, EX/MEM and MEM/WB registers.

---
 rtl/pipe_ctrl_if.sv | 48 ++++
 rtl/pipe_ctrl_unit.sv | 172 +++++++++++++++++
 tb/tb_pipe_ctrl_unit.sv | 250 +++++++++++++++++++++++++
 3 files changed

// File: rtl/pipe_ctrl_if.sv
// pipe_ctrl_if: bundles the pipeline-control signals exchanged between the
// CPU's ID/EX/MEM/WB datapath and pipe_ctrl_unit.
//   master : the datapath side. Drives the ID instruction fields and flush,
//            and receives stall, the EX/MEM/WB controls and the forwarding selects.
//   slave  : pipe_ctrl_unit itself.
// Signals:
//   id_valid, id_opcode, id_rs, id_rt, id_rd : instruction currently in ID
//   flush         : squash the ID instruction
//   stall         : hold PC and IF/ID this cycle (combinational)
//   ex_alu_op, ex_alu_src, ex_fwd_a, ex_fwd_b : EX-stage controls
//   mem_w, mem_r  : MEM-stage controls
//   wb_reg_w, wb_mem_to_reg, wb_dest : WB-stage controls
//   illegal_op    : undefined opcode currently in EX
interface pipe_ctrl_if #(
  parameter int OP_W    = 4,
  parameter int RA_W    = 4,
  parameter int ALUOP_W = 2
) ();
  logic               id_valid;
  logic [OP_W-1:0]    id_opcode;
  logic [RA_W-1:0]    id_rs;
  logic [RA_W-1:0]    id_rt;
  logic [RA_W-1:0]    id_rd;
  logic               flush;
  logic               stall;
  logic [ALUOP_W-1:0] ex_alu_op;
  logic               ex_alu_src;
  logic [1:0]         ex_fwd_a;
  logic [1:0]         ex_fwd_b;
  logic               mem_w;
  logic               mem_r;
  logic               wb_reg_w;
  logic               wb_mem_to_reg;
  logic [RA_W-1:0]    wb_dest;
  logic               illegal_op;

  modport master (
    output id_valid, id_opcode, id_rs, id_rt, id_rd, flush,
    input  stall, ex_alu_op, ex_alu_src, ex_fwd_a, ex_fwd_b,
           mem_w, mem_r, wb_reg_w, wb_mem_to_reg, wb_dest, illegal_op
  );

  modport slave (
    input  id_valid, id_opcode, id_rs, id_rt, id_rd, flush,
    output stall, ex_alu_op, ex_alu_src, ex_fwd_a, ex_fwd_b,
           mem_w, mem_r, wb_reg_w, wb_mem_to_reg, wb_dest, illegal_op
  );
endinterface

// File: rtl/pipe_ctrl_unit.sv
// pipe_ctrl_unit: pipelined control for a 5-stage CPU.
// Decodes the ID opcode, carries the control bits through ID/EX, EX/MEM and
// MEM/WB, detects load-use hazards (stall + bubble) and produces the EX-stage
// operand forwarding selects.
// Ports:
//   clk : rising-edge clock
//   rst : synchronous active-high reset; all pipeline registers become bubbles
//   bus : pipe_ctrl_if slave modport (ID inputs, flush, stall and stage controls)
module pipe_ctrl_unit #(
  parameter int OP_W    = 4,
  parameter int RA_W    = 4,
  parameter int ALUOP_W = 2
) (
  input  logic        clk,
  input  logic        rst,
  pipe_ctrl_if.slave  bus
);

  localparam logic [OP_W-1:0] OP_R    = OP_W'('b0000);
  localparam logic [OP_W-1:0] OP_LW   = OP_W'('b0011);
  localparam logic [OP_W-1:0] OP_SW   = OP_W'('b1011);
  localparam logic [OP_W-1:0] OP_ADDI = OP_W'('b1001);
  localparam logic [OP_W-1:0] OP_ORI  = OP_W'('b1101);

  localparam logic [ALUOP_W-1:0] ALU_FUNCT = ALUOP_W'('b00);
  localparam logic [ALUOP_W-1:0] ALU_ADD   = ALUOP_W'('b01);
  localparam logic [ALUOP_W-1:0] ALU_OR    = ALUOP_W'('b11);

  // All-zero value of each register type is the bubble.
  typedef struct packed {
    logic               reg_w;
    logic               mem_r;
    logic               mem_w;
    logic               m2r;
    logic               illegal;
    logic               alu_src;
    logic [ALUOP_W-1:0] alu_op;
    logic [RA_W-1:0]    dest;
    logic [RA_W-1:0]    rs;
    logic [RA_W-1:0]    rt;
    logic               uses_rt;
  } id_ex_t;

  typedef struct packed {
    logic            reg_w;
    logic            mem_r;
    logic            mem_w;
    logic            m2r;
    logic [RA_W-1:0] dest;
  } ex_mem_t;

  typedef struct packed {
    logic            reg_w;
    logic            m2r;
    logic [RA_W-1:0] dest;
  } mem_wb_t;

  id_ex_t  dec;
  id_ex_t  id_ex_next;
  id_ex_t  id_ex_reg;
  ex_mem_t ex_mem_reg;
  mem_wb_t mem_wb_reg;
  logic    id_uses_rt;
  logic    stall;

  // ID decode. Register fields are only kept for operands the instruction
  // really reads, so a bubble or an undefined opcode never forwards.
  always_comb begin
    dec = '0;
    case (bus.id_opcode)
      OP_R: begin
        dec.reg_w   = 1'b1;
        dec.dest    = bus.id_rd;
        dec.alu_op  = ALU_FUNCT;
        dec.rs      = bus.id_rs;
        dec.rt      = bus.id_rt;
        dec.uses_rt = 1'b1;
      end
      OP_ADDI: begin
        dec.reg_w   = 1'b1;
        dec.dest    = bus.id_rt;
        dec.alu_op  = ALU_ADD;
        dec.alu_src = 1'b1;
        dec.rs      = bus.id_rs;
      end
      OP_LW: begin
        dec.reg_w   = 1'b1;
        dec.mem_r   = 1'b1;
        dec.m2r     = 1'b1;
        dec.dest    = bus.id_rt;
        dec.alu_op  = ALU_ADD;
        dec.alu_src = 1'b1;
        dec.rs      = bus.id_rs;
      end
      OP_SW: begin
        dec.mem_w   = 1'b1;
        dec.alu_op  = ALU_ADD;
        dec.alu_src = 1'b1;
        dec.rs      = bus.id_rs;
        dec.rt      = bus.id_rt;
        dec.uses_rt = 1'b1;
      end
      OP_ORI: begin
        dec.reg_w   = 1'b1;
        dec.dest    = bus.id_rt;
        dec.alu_op  = ALU_OR;
        dec.alu_src = 1'b1;
        dec.rs      = bus.id_rs;
      end
      default: dec.illegal = 1'b1;
    endcase
    // r0 is hardwired zero: a write to it is no write at all.
    if (dec.dest == '0) dec.reg_w = 1'b0;
  end

  // Load-use hazard against the load sitting in EX. Uses the raw ID fields so
  // the check does not depend on how the ID opcode decodes.
  assign id_uses_rt = (bus.id_opcode == OP_R) || (bus.id_opcode == OP_SW);
  assign stall = bus.id_valid && !bus.flush && id_ex_reg.mem_r &&
                 (id_ex_reg.dest != '0) &&
                 ((id_ex_reg.dest == bus.id_rs) ||
                  (id_uses_rt && (id_ex_reg.dest == bus.id_rt)));

  // Flush dominates stall since stall is already gated by !flush.
  assign id_ex_next = (!bus.id_valid || bus.flush || stall) ? id_ex_t'('0) : dec;

  always_ff @(posedge clk) begin
    if (rst) begin
      id_ex_reg  <= '0;
      ex_mem_reg <= '0;
      mem_wb_reg <= '0;
    end else begin
      id_ex_reg  <= id_ex_next;
      ex_mem_reg <= '{reg_w: id_ex_reg.reg_w, mem_r: id_ex_reg.mem_r,
                      mem_w: id_ex_reg.mem_w, m2r: id_ex_reg.m2r,
                      dest: id_ex_reg.dest};
      mem_wb_reg <= '{reg_w: ex_mem_reg.reg_w, m2r: ex_mem_reg.m2r,
                      dest: ex_mem_reg.dest};
    end
  end

  // Forwarding selects for EX operand A (gi=0, rs) and B (gi=1, rt).
  // The younger producer in MEM wins over the older one in WB.
  logic [RA_W-1:0] ex_src  [2];
  logic [1:0]      fwd_sel [2];

  assign ex_src[0] = id_ex_reg.rs;
  assign ex_src[1] = id_ex_reg.rt;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_fwd
      assign fwd_sel[gi] =
        (ex_mem_reg.reg_w && (ex_mem_reg.dest != '0) && (ex_mem_reg.dest == ex_src[gi])) ? 2'b10 :
        (mem_wb_reg.reg_w && (mem_wb_reg.dest != '0) && (mem_wb_reg.dest == ex_src[gi])) ? 2'b01 :
        2'b00;
    end
  endgenerate

  assign bus.stall         = stall;
  assign bus.ex_alu_op     = id_ex_reg.alu_op;
  assign bus.ex_alu_src    = id_ex_reg.alu_src;
  assign bus.ex_fwd_a      = fwd_sel[0];
  assign bus.ex_fwd_b      = id_ex_reg.uses_rt ? fwd_sel[1] : 2'b00;
  assign bus.illegal_op    = id_ex_reg.illegal;
  assign bus.mem_w         = ex_mem_reg.mem_w;
  assign bus.mem_r         = ex_mem_reg.mem_r;
  assign bus.wb_reg_w      = mem_wb_reg.reg_w;
  assign bus.wb_mem_to_reg = mem_wb_reg.m2r;
  assign bus.wb_dest       = mem_wb_reg.dest;

endmodule

// File: tb/tb_pipe_ctrl_unit.sv
// tb_pipe_ctrl_unit: drives directed and random instruction streams into
// pipe_ctrl_unit. The driver pushes the expected outputs of every cycle into a
// queue; an independent monitor pops and compares them on the falling edge.
module tb_pipe_ctrl_unit;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  pipe_ctrl_if #(.OP_W(4), .RA_W(4), .ALUOP_W(2)) bus ();

  pipe_ctrl_unit #(.OP_W(4), .RA_W(4), .ALUOP_W(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  typedef struct {
    bit       v;
    bit [3:0] op;
    bit [3:0] rs;
    bit [3:0] rt;
    bit [3:0] rd;
  } instr_t;

  typedef struct {
    bit     rst;
    bit     fl;
    instr_t i;
  } stim_t;

  typedef struct {
    bit       stall;
    bit [1:0] alu_op;
    bit       alu_src;
    bit [1:0] fa;
    bit [1:0] fb;
    bit       mem_w;
    bit       mem_r;
    bit       reg_w;
    bit       m2r;
    bit [3:0] dest;
    bit       ill;
  } exp_t;

  stim_t  stim_q [$];
  exp_t   exp_q  [$];
  instr_t pipe   [3];   // reference view: [0]=EX, [1]=MEM, [2]=WB
  int     total = 0;
  int     bad   = 0;
  int     cyc   = 0;

  task automatic chk(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s cyc=%0d: got %0d want %0d", name, cyc, act, req);
    end
  endtask

  function automatic bit known(input bit [3:0] op);
    return op == 4'd0 || op == 4'd3 || op == 4'd11 || op == 4'd9 || op == 4'd13;
  endfunction

  function automatic bit reads_rt(input bit [3:0] op);
    return op == 4'd0 || op == 4'd11;
  endfunction

  // Register actually written by an instruction (0 means no write).
  function automatic bit [3:0] wdest(input instr_t i);
    if (!i.v) return 4'd0;
    case (i.op)
      4'd0:                return i.rd;
      4'd3, 4'd9, 4'd13:   return i.rt;
      default:             return 4'd0;
    endcase
  endfunction

  function automatic bit [1:0] fwd(input bit [3:0] r);
    if (wdest(pipe[1]) != 0 && wdest(pipe[1]) == r) return 2'b10;
    if (wdest(pipe[2]) != 0 && wdest(pipe[2]) == r) return 2'b01;
    return 2'b00;
  endfunction

  function automatic exp_t expect_now(input stim_t s);
    exp_t   e;
    instr_t x;
    bit     ok;
    x  = pipe[0];
    ok = x.v && known(x.op);
    e.stall = s.i.v && !s.fl && pipe[0].v && pipe[0].op == 4'd3 && pipe[0].rt != 0 &&
              (pipe[0].rt == s.i.rs || (reads_rt(s.i.op) && pipe[0].rt == s.i.rt));
    e.alu_op  = !ok ? 2'b00 : (x.op == 4'd0) ? 2'b00 : (x.op == 4'd13) ? 2'b11 : 2'b01;
    e.alu_src = ok && x.op != 4'd0;
    e.fa      = ok ? fwd(x.rs) : 2'b00;
    e.fb      = (ok && reads_rt(x.op)) ? fwd(x.rt) : 2'b00;
    e.ill     = x.v && !known(x.op);
    e.mem_w   = pipe[1].v && pipe[1].op == 4'd11;
    e.mem_r   = pipe[1].v && pipe[1].op == 4'd3;
    e.dest    = wdest(pipe[2]);
    e.reg_w   = e.dest != 0;
    e.m2r     = pipe[2].v && pipe[2].op == 4'd3;
    return e;
  endfunction

  task automatic add(input bit r, input bit f, input bit v, input int op,
                     input int rs, input int rt, input int rd);
    stim_t s;
    s.rst = r; s.fl = f; s.i.v = v;
    s.i.op = 4'(op); s.i.rs = 4'(rs); s.i.rt = 4'(rt); s.i.rd = 4'(rd);
    stim_q.push_back(s);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) add(0, 0, 0, 0, 0, 0, 0);
  endtask

  // Monitor: one comparison set per presented cycle.
  exp_t mon_e;
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      chk("stall",      int'(bus.stall),         int'(mon_e.stall));
      chk("ex_alu_op",  int'(bus.ex_alu_op),     int'(mon_e.alu_op));
      chk("ex_alu_src", int'(bus.ex_alu_src),    int'(mon_e.alu_src));
      chk("ex_fwd_a",   int'(bus.ex_fwd_a),      int'(mon_e.fa));
      chk("ex_fwd_b",   int'(bus.ex_fwd_b),      int'(mon_e.fb));
      chk("illegal_op", int'(bus.illegal_op),    int'(mon_e.ill));
      chk("mem_w",      int'(bus.mem_w),         int'(mon_e.mem_w));
      chk("mem_r",      int'(bus.mem_r),         int'(mon_e.mem_r));
      chk("wb_reg_w",   int'(bus.wb_reg_w),      int'(mon_e.reg_w));
      chk("wb_m2r",     int'(bus.wb_mem_to_reg), int'(mon_e.m2r));
      chk("wb_dest",    int'(bus.wb_dest),       int'(mon_e.dest));
      $display("cyc %0d rst=%0d stall=%0d fa=%0d fb=%0d ill=%0d mem_r=%0d mem_w=%0d wb_w=%0d dest=%0d",
               cyc, rst, bus.stall, bus.ex_fwd_a, bus.ex_fwd_b, bus.illegal_op,
               bus.mem_r, bus.mem_w, bus.wb_reg_w, bus.wb_dest);
    end
  end

  initial begin
    stim_t  s;
    stim_t  cur;
    instr_t bubble;
    instr_t acc;
    instr_t held_i;
    bit     held;
    bit     cur_stall;
    exp_t   e;
    int     sel;

    bubble = '{v: 1'b0, op: 4'd0, rs: 4'd0, rt: 4'd0, rd: 4'd0};
    held = 1'b0;
    cur_stall = 1'b0;

    // Reset for two cycles, then addi r1.
    add(1, 0, 0, 0, 0, 0, 0);
    add(0, 0, 1, 9, 0, 1, 0);
    idle(3);
    // lw r2 then R-type reading r2: one-cycle stall, later WB forward.
    add(0, 0, 1, 3, 0, 2, 0);
    add(0, 0, 1, 0, 2, 5, 6);
    idle(3);
    // addi r3 then R rs=3 rt=3 (MEM forward), then with a gap (WB forward).
    add(0, 0, 1, 9, 0, 3, 0);
    add(0, 0, 1, 0, 3, 3, 7);
    idle(3);
    add(0, 0, 1, 9, 0, 3, 0);
    add(0, 0, 1, 9, 1, 8, 0);
    add(0, 0, 1, 0, 3, 3, 7);
    idle(3);
    // lw r4 followed by a flushed reader of r4.
    add(0, 0, 1, 3, 0, 4, 0);
    add(0, 1, 1, 0, 4, 4, 5);
    idle(3);
    // Undefined opcode; addi to r0 then a reader of r0.
    add(0, 0, 1, 7, 1, 2, 3);
    idle(3);
    add(0, 0, 1, 9, 1, 0, 0);
    add(0, 0, 1, 0, 0, 0, 5);
    idle(3);
    // Reset while lw is in EX and a dependent instruction is stalled in ID.
    add(0, 0, 1, 3, 0, 4, 0);
    add(1, 0, 1, 0, 4, 1, 2);
    add(0, 0, 1, 0, 4, 1, 2);
    idle(3);
    // Random stream with small register range to provoke hazards.
    for (int n = 0; n < 500; n++) begin
      sel = int'($urandom_range(0, 9));
      add(($urandom_range(0, 49) == 0), ($urandom_range(0, 9) == 0),
          ($urandom_range(0, 9) != 0),
          (sel < 2) ? 0 : (sel < 4) ? 3 : (sel < 5) ? 11 : (sel < 7) ? 9 :
          (sel < 9) ? 13 : int'($urandom_range(0, 15)),
          int'($urandom_range(0, 5)), int'($urandom_range(0, 5)),
          int'($urandom_range(0, 5)));
    end

    rst = 1'b1;
    bus.id_valid = 1'b0; bus.id_opcode = '0; bus.id_rs = '0;
    bus.id_rt = '0; bus.id_rd = '0; bus.flush = 1'b0;
    cur.rst = 1'b1; cur.fl = 1'b0; cur.i = bubble;
    @(posedge clk); #1;

    while (stim_q.size() > 0 || held) begin
      // Advance the reference pipeline over the edge just taken.
      if (cur.rst) begin
        pipe[0] = bubble; pipe[1] = bubble; pipe[2] = bubble;
      end else begin
        acc = (cur.i.v && !cur.fl && !cur_stall) ? cur.i : bubble;
        pipe[2] = pipe[1];
        pipe[1] = pipe[0];
        pipe[0] = acc;
      end
      cyc++;

      if (held) begin
        s.rst = 1'b0; s.fl = 1'b0; s.i = held_i;
      end else begin
        s = stim_q.pop_front();
      end

      rst          = s.rst;
      bus.flush    = s.fl;
      bus.id_valid = s.i.v;
      bus.id_opcode = s.i.op;
      bus.id_rs    = s.i.rs;
      bus.id_rt    = s.i.rt;
      bus.id_rd    = s.i.rd;

      e = expect_now(s);
      exp_q.push_back(e);
      cur_stall = e.stall;
      held   = e.stall && !s.rst;
      held_i = s.i;
      cur    = s;
      @(posedge clk); #1;
    end

    chk("scoreboard_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Absolute time limit so the bench always ends.
  initial begin
    #200000;
    $display("FAIL timeout: got running want finished");
    $fatal(1, "time limit reached");
  end

endmodule
